// File: rtl/conv_pkg.sv
// -----------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 3x3 conv window sequencer.
//   state_t      : sequencer FSM states
//   last_origin  : last legal window origin along one dimension (SIZE-SIZEKer)
//   norm_stride  : maps a stride of 0 onto 1 so the walk always makes progress
// -----------------------------------------------------------------------------
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_t;

  function automatic int last_origin(input int size, input int size_ker);
    return size - size_ker;
  endfunction

  function automatic logic [1:0] norm_stride(input logic [1:0] stride);
    return (stride == 2'd0) ? 2'd1 : stride;
  endfunction

endpackage

// File: rtl/win_cursor.sv
// -----------------------------------------------------------------------------
// win_cursor
// Holds the current window origin (win_row/win_col) and the matching
// output-map coordinates (out_row/out_col), stepping in raster order.
// Ports:
//   clock, nreset : clock and synchronous active-low reset
//   clear         : return to origin (0,0)
//   advance       : step to the next origin using stride
//   stride        : normalised step (1..3)
//   win_row/col   : window origin for the loader
//   out_row/col   : output-map coordinates of the current origin
//   last_pos      : current origin is the final one of the pass
// -----------------------------------------------------------------------------
module win_cursor
  import conv_pkg::*;
#(
  parameter int SIZE      = 7,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 8
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [1:0]           stride,
  output logic [WIDTH_BIT-1:0] win_row,
  output logic [WIDTH_BIT-1:0] win_col,
  output logic [WIDTH_BIT-1:0] out_row,
  output logic [WIDTH_BIT-1:0] out_col,
  output logic                 last_pos
);

  localparam int                   LAST_I = last_origin(SIZE, SIZEKer);
  localparam logic [WIDTH_BIT-1:0] LAST   = LAST_I[WIDTH_BIT-1:0];

  logic [WIDTH_BIT-1:0] r_win_row, r_win_col, r_out_row, r_out_col;
  logic [WIDTH_BIT-1:0] w_step, w_col_next, w_row_next;
  logic                 w_col_fits, w_row_fits;

  // SIZE <= 2^(WIDTH_BIT-1) keeps origin+stride from wrapping, so a plain
  // unsigned compare against LAST is enough.
  assign w_step     = WIDTH_BIT'(stride);
  assign w_col_next = r_win_col + w_step;
  assign w_row_next = r_win_row + w_step;
  assign w_col_fits = (w_col_next <= LAST);
  assign w_row_fits = (w_row_next <= LAST);
  assign last_pos   = !w_col_fits && !w_row_fits;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (!nreset || clear) begin
      r_win_row <= '0;
      r_win_col <= '0;
      r_out_row <= '0;
      r_out_col <= '0;
    end else if (advance) begin
      if (w_col_fits) begin
        r_win_col <= w_col_next;
        r_out_col <= r_out_col + 1'b1;
      end else begin
        r_win_col <= '0;
        r_out_col <= '0;
        r_win_row <= w_row_next;
        r_out_row <= r_out_row + 1'b1;
      end
    end
  end

  assign win_row = r_win_row;
  assign win_col = r_win_col;
  assign out_row = r_out_row;
  assign out_col = r_out_col;

endmodule

// File: rtl/conv_window_sched.sv
// -----------------------------------------------------------------------------
// conv_window_sched
// Sequencer for the shared 3x3 conv engine. For every window origin it
// strobes the loader, starts the engine, waits for its result and presents
// the result with output coordinates on a valid/ready write port.
// Ports:
//   clock, nreset          : clock and synchronous active-low reset
//   start, abort, stride   : pass control (stride sampled at start, 0 -> 1)
//   busy, done             : pass status; done pulses on normal completion
//   win_row, win_col       : window origin; win_load strobes the loader
//   eng_start              : engine start pulse
//   eng_done, eng_result   : engine completion and result
//   out_valid, out_ready   : write handshake to the feature-map buffer
//   out_row/col, out_data  : write coordinates and data
//   win_count              : results accepted in the current pass
// -----------------------------------------------------------------------------
module conv_window_sched
  import conv_pkg::*;
#(
  parameter int SIZE      = 7,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 8
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [1:0]           stride,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH_BIT-1:0] win_row,
  output logic [WIDTH_BIT-1:0] win_col,
  output logic                 win_load,
  output logic                 eng_start,
  input  logic                 eng_done,
  input  logic [WIDTH_BIT-1:0] eng_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_BIT-1:0] out_row,
  output logic [WIDTH_BIT-1:0] out_col,
  output logic [WIDTH_BIT-1:0] out_data,
  output logic [WIDTH_BIT-1:0] win_count
);

  state_t               r_state, w_next;
  logic [1:0]           r_stride;
  logic [WIDTH_BIT-1:0] r_out_data, r_win_count;
  logic                 w_go, w_accept, w_advance, w_last_pos;

  win_cursor #(
    .SIZE      (SIZE),
    .SIZEKer   (SIZEKer),
    .WIDTH_BIT (WIDTH_BIT)
  ) u_cursor (
    .clock    (clock),
    .nreset   (nreset),
    .clear    (w_go),
    .advance  (w_advance),
    .stride   (r_stride),
    .win_row  (win_row),
    .win_col  (win_col),
    .out_row  (out_row),
    .out_col  (out_col),
    .last_pos (w_last_pos)
  );

  always_ff @(posedge clock) begin
    if (!nreset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next    = r_state;
    win_load  = 1'b0;
    eng_start = 1'b0;
    out_valid = 1'b0;
    w_go      = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !abort) begin
          w_go   = 1'b1;
          w_next = LOAD;
        end
      end
      LOAD: begin
        win_load = !abort;
        w_next   = START;
      end
      START: begin
        eng_start = !abort;
        w_next    = WAIT;
      end
      WAIT: begin
        if (eng_done) w_next = WRITE;
      end
      WRITE: begin
        // Gating with abort means an aborted write is never handshaken.
        out_valid = !abort;
        if (out_ready && !abort) begin
          w_accept = 1'b1;
          w_next   = w_last_pos ? DONE : LOAD;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (abort && (r_state != IDLE)) w_next = IDLE;
  end

  assign w_advance = w_accept && !w_last_pos;

  always_ff @(posedge clock) begin
    if (!nreset) begin
      r_stride    <= '0;
      r_out_data  <= '0;
      r_win_count <= '0;
    end else begin
      if (w_go) begin
        r_stride    <= norm_stride(stride);
        r_win_count <= '0;
      end else if (w_accept) begin
        r_win_count <= r_win_count + 1'b1;
      end
      if ((r_state == WAIT) && eng_done && !abort) r_out_data <= eng_result;
    end
  end

  assign busy      = (r_state != IDLE);
  assign done      = (r_state == DONE);
  assign out_data  = r_out_data;
  assign win_count = r_win_count;

endmodule

// File: tb/tb_conv_window_sched.sv
// -----------------------------------------------------------------------------
// tb_conv_window_sched
// Directed bench for conv_window_sched (SIZE=7, SIZEKer=3, WIDTH_BIT=8).
// The engine model answers win_row*16+win_col after a configurable latency;
// the expected raster walk is generated per pass from the stride.
// Inputs are driven on the falling edge, outputs sampled there as well.
// -----------------------------------------------------------------------------
module tb_conv_window_sched;

  logic       clock = 1'b0;
  logic       nreset, start, abort, eng_done, out_ready;
  logic [1:0] stride;
  logic [7:0] eng_result;
  logic       busy, done, win_load, eng_start, out_valid;
  logic [7:0] win_row, win_col, out_row, out_col, out_data, win_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  conv_window_sched #(
    .SIZE      (7),
    .SIZEKer   (3),
    .WIDTH_BIT (8)
  ) dut (
    .clock      (clock),
    .nreset     (nreset),
    .start      (start),
    .abort      (abort),
    .stride     (stride),
    .busy       (busy),
    .done       (done),
    .win_row    (win_row),
    .win_col    (win_col),
    .win_load   (win_load),
    .eng_start  (eng_start),
    .eng_done   (eng_done),
    .eng_result (eng_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_data   (out_data),
    .win_count  (win_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One pass. abort_win: abort in WAIT of that window (0 = none).
  // rst_write: pull nreset in WRITE of that write (0 = none).
  // noise: start/stride change while busy plus a spurious eng_done in LOAD.
  task automatic run_pass(input int stride_in, input int lat, input int stall_idx,
                          input int stall_len, input int abort_win, input int rst_write,
                          input bit noise);
    int s, n_exp, n_acc, n_started, cyc, last_acc, eng_wait, stall_left;
    int er[25], ec[25], eor[25], eoc[25];
    bit eng_pend, in_write, excl_bad, finished, abort_sent, rst_sent, done_seen;
    logic [7:0]  eng_val;
    logic [23:0] held;

    s = (stride_in == 0) ? 1 : stride_in;
    n_exp = 0; n_acc = 0; n_started = 0; cyc = 0; last_acc = 0; eng_wait = 0;
    stall_left = 0; eng_pend = 0; in_write = 0; excl_bad = 0; finished = 0;
    abort_sent = 0; rst_sent = 0; done_seen = 0; eng_val = '0; held = '0;
    for (int r = 0; r <= 4; r += s) begin
      for (int c = 0; c <= 4; c += s) begin
        er[n_exp] = r; ec[n_exp] = c; eor[n_exp] = r / s; eoc[n_exp] = c / s;
        n_exp++;
      end
    end

    @(negedge clock);
    check("idle_before_start", {31'd0, busy}, 32'd0);
    start  = 1'b1;
    stride = 2'(stride_in);

    while (!finished && cyc < 1000) begin
      @(negedge clock);
      cyc++;
      start = 1'b0; abort = 1'b0; eng_done = 1'b0; out_ready = 1'b0;
      if (int'(win_load) + int'(eng_start) + int'(out_valid) > 1) excl_bad = 1'b1;

      if (abort_sent) begin
        check("abort_idle", {busy, done, win_load, eng_start, out_valid}, 32'd0);
        check("abort_count", win_count, abort_win - 1);
        finished = 1'b1;
      end else if (rst_sent) begin
        check("rst_flags", {busy, done, win_load, eng_start, out_valid}, 32'd0);
        check("rst_idx", {win_row, win_col, out_row, out_col}, 32'd0);
        check("rst_data", {out_data, win_count}, 32'd0);
        nreset   = 1'b1;
        finished = 1'b1;
      end else if (done_seen) begin
        check("done_single", {busy, done}, 32'd0);
        finished = 1'b1;
      end else begin
        if (cyc == 1) check("first_load", {win_load, win_count, win_row, win_col}, {1'b1, 24'd0});
        if (noise && cyc == 2) begin
          start  = 1'b1;
          stride = 2'd3;
        end
        if (noise && win_load && n_started == 2) begin
          eng_done   = 1'b1;
          eng_result = 8'hEE;
        end

        // Engine model.
        if (eng_start) begin
          eng_pend = 1'b1;
          eng_wait = 0;
          eng_val  = 8'(win_row * 16 + win_col);
          n_started++;
        end else if (eng_pend) begin
          eng_wait++;
          if (abort_win != 0 && n_started == abort_win) begin
            abort      = 1'b1;
            abort_sent = 1'b1;
            eng_pend   = 1'b0;
          end else if (eng_wait >= lat) begin
            eng_done   = 1'b1;
            eng_result = eng_val;
            eng_pend   = 1'b0;
          end
        end

        // Output buffer model.
        if (out_valid) begin
          if (!in_write) begin
            in_write   = 1'b1;
            held       = {out_row, out_col, out_data};
            stall_left = (n_acc + 1 == stall_idx) ? stall_len : 0;
          end else begin
            check("write_hold", {out_row, out_col, out_data}, held);
          end
          if (rst_write == n_acc + 1) begin
            nreset   = 1'b0;
            rst_sent = 1'b1;
          end else if (stall_left > 0) begin
            stall_left--;
          end else begin
            out_ready = 1'b1;
            if (n_acc < n_exp) begin
              check("wr_pos", {win_row, win_col, out_row, out_col},
                    {8'(er[n_acc]), 8'(ec[n_acc]), 8'(eor[n_acc]), 8'(eoc[n_acc])});
              check("wr_data", out_data, 8'(er[n_acc] * 16 + ec[n_acc]));
            end else begin
              check("wr_extra", n_acc, n_exp);
            end
            check("count_live", win_count, n_acc);
            if (n_acc > 0)
              check("spacing", cyc - last_acc,
                    3 + lat + ((n_acc + 1 == stall_idx) ? stall_len : 0));
            last_acc = cyc;
            n_acc++;
            in_write = 1'b0;
          end
        end

        if (done) begin
          check("done_no_abort", abort_win, 0);
          check("done_latency", cyc - last_acc, 1);
          check("done_count", win_count, n_exp);
          check("writes", n_acc, n_exp);
          done_seen = 1'b1;
        end
      end
    end

    check("pass_complete", {31'd0, finished}, 32'd1);
    check("exclusive_strobes", {31'd0, excl_bad}, 32'd0);
    start = 1'b0; abort = 1'b0; eng_done = 1'b0; out_ready = 1'b0; nreset = 1'b1;
  endtask

  initial begin
    nreset = 1'b0; start = 1'b0; abort = 1'b0; stride = 2'd0;
    eng_done = 1'b0; eng_result = 8'd0; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("reset_flags", {busy, done, win_load, eng_start, out_valid}, 32'd0);
    check("reset_idx", {win_row, win_col, out_row, out_col}, 32'd0);
    check("reset_data", {out_data, win_count}, 32'd0);
    nreset = 1'b1;

    run_pass(1, 1, 0, 0, 0, 0, 1'b0);  // 25 writes, 4 cycles apart
    run_pass(2, 1, 0, 0, 0, 0, 1'b0);  // 9 writes
    run_pass(3, 1, 0, 0, 0, 0, 1'b0);  // 4 writes, last at (3,3)
    run_pass(0, 1, 0, 0, 0, 0, 1'b0);  // stride 0 behaves as 1
    run_pass(1, 5, 2, 3, 0, 0, 1'b1);  // latency 5, stall on write #2, noise
    run_pass(1, 1, 0, 0, 7, 0, 1'b0);  // abort in WAIT of window 7
    run_pass(1, 1, 0, 0, 0, 0, 1'b0);  // clean restart after abort

    // Abort wins over a simultaneous start in IDLE.
    @(negedge clock);
    start = 1'b1; abort = 1'b1; stride = 2'd1;
    @(negedge clock);
    check("abort_beats_start", {31'd0, busy}, 32'd0);
    start = 1'b0; abort = 1'b0;

    run_pass(1, 1, 0, 0, 0, 3, 1'b0);  // reset during WRITE of write #3
    run_pass(2, 1, 0, 0, 0, 0, 1'b0);  // normal pass after reset

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_window_sched.md
Name: conv_window_sched

Overview:
- Sequencer for the shared 3x3 conv engine.
- Walks the window origin across a SIZE x SIZE input using a runtime stride.
- For each origin it strobes the window-load register, starts the engine, and waits for the engine's completion.
- It then presents the result with output coordinates on a valid/ready write port to the feature-map buffer.
- Sits between the top-level control (start/abort/done) and the conv engine plus output buffer.

Parameters:
- SIZE, 7, input image dimension (square).
- SIZEKer, 3, kernel dimension (square).
- WIDTH_BIT, 8, width of data words and all index/count outputs.

Ports:
- clock  in  1  rising-edge clock.
- nreset  in  1  synchronous active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- abort  in  1  synchronous cancel of the current pass.
- stride  in  2  window step; sampled at start; 0 treated as 1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a pass completes normally.
- win_row  out  WIDTH_BIT  window origin row for the loader.
- win_col  out  WIDTH_BIT  window origin column for the loader.
- win_load  out  1  one-cycle strobe; loader captures window at win_row/win_col.
- eng_start  out  1  one-cycle pulse that starts the conv engine.
- eng_done  in  1  engine result valid; sampled only in WAIT.
- eng_result  in  WIDTH_BIT  engine result, captured when eng_done is seen.
- out_valid  out  1  write request to the output buffer.
- out_ready  in  1  buffer accepts the write.
- out_row  out  WIDTH_BIT  output-map row index.
- out_col  out  WIDTH_BIT  output-map column index.
- out_data  out  WIDTH_BIT  captured result.
- win_count  out  WIDTH_BIT  number of results accepted in the current pass.

Behaviour:
- Reset (nreset=0 at a clock edge): state=IDLE. All outputs and registers are 0, including the latched stride.
- Last origin value: LAST = SIZE-SIZEKer.
- Outputs per dimension: N = floor(LAST/stride)+1.
- States:
  - IDLE: on start && !abort, latch stride (0 becomes 1), clear win_row/win_col/out_row/out_col/win_count, go to LOAD.
  - LOAD: win_load=1 for exactly this cycle; win_row/win_col stable. Go to START.
  - START: eng_start=1 for exactly this cycle. Go to WAIT.
  - WAIT: stay until eng_done=1. In the cycle eng_done=1, register eng_result into out_data and go to WRITE.
  - WRITE: out_valid=1. out_row/out_col/out_data are held stable until out_valid && out_ready.
    - On acceptance: win_count+1.
    - If win_row==last row origin and win_col==last col origin, go to DONE.
    - Otherwise advance and go to LOAD.
  - DONE: done=1 for one cycle, busy=1. Go to IDLE.
- Advance rule:
  - If win_col+stride <= LAST: win_col += stride, out_col += 1.
  - Else: win_col=0, out_col=0, win_row += stride, out_row += 1.
  - The last origin is reached when win_col+stride > LAST and win_row+stride > LAST.
  - Index arithmetic is WIDTH_BIT wide; SIZE <= 2^(WIDTH_BIT-1) is required.
- Timing: minimum 4 cycles per window (LOAD, START, WAIT with eng_done in the cycle after START, WRITE with out_ready=1).
  - Each extra engine latency cycle or ready stall adds one cycle.
  - done asserts the cycle after the final accepted write.
- Abort:
  - In any non-IDLE state, abort=1 causes state=IDLE next cycle.
  - out_valid, win_load and eng_start deassert; no done pulse.
  - win_count holds its value until the next start.
  - In IDLE, abort wins over a simultaneous start.
- Ignored inputs:
  - start while busy.
  - eng_done outside WAIT.
  - out_ready outside WRITE.
  - stride changes mid-pass.
- Reset mid-pass behaves as abort, and additionally clears all registers.
- At most one of win_load, eng_start, out_valid is high in any cycle.

Decomposition:
- Shared package conv_pkg:
  - State enum typedef: IDLE, LOAD, START, WAIT, WRITE, DONE.
  - Function computing LAST from SIZE/SIZEKer.
  - Function normalising stride.
- Sub-module win_cursor holds win_row/win_col/out_row/out_col.
  - Inputs: clear, advance, stride.
  - Output: last_pos flag.
- The FSM lives in conv_window_sched.

Test Plan:
- SIZE=7, SIZEKer=3, stride=1; engine model returns row*16+col with 1-cycle latency; out_ready=1.
  - Expect 25 writes in raster order, (0,0)=0x00 through (4,4)=0x44.
  - Writes are 4 cycles apart; win_count=25; done pulse one cycle after the last write.
- Same setup, stride=2.
  - Expect 9 writes; win origins {0,2,4}x{0,2,4}; out indices 0..2; last out_data=0x44 at out(2,2).
- Stride=3.
  - Expect origins {0,3}, 4 writes; last at win(3,3), out(1,1).
- Stride=0.
  - Expect behaviour identical to stride=1.
- Engine latency 5 and out_ready low for 3 cycles on write #2.
  - Expect out_row/out_col/out_data held stable during the stall; per-window spacing grows accordingly; total 25 writes.
- Abort asserted during WAIT of window 7.
  - Expect IDLE next cycle, no done, win_count=6.
  - A following start restarts at (0,0) with win_count cleared.
- Also check:
  - nreset low in WRITE gives all outputs 0 next edge.
  - start asserted while busy has no effect.
  - A spurious eng_done in LOAD is ignored.
